// File: rtl/ram_fifo_pkg.sv
// Shared constants and sizing helpers for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int DEF_D_WIDTH   = 16;
    localparam int DEF_A_WIDTH   = 5;
    localparam int DEF_AE_THRESH = 2;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // Level counts 0..DEPTH inclusive, so it needs one bit more than a pointer.
    function automatic int level_width(input int aw);
        return aw + 1;
    endfunction

    function automatic int def_af_thresh(input int aw);
        return (1 << aw) - 2;
    endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM address pointer with increment enable and synchronous clear.
module ram_fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [A_WIDTH-1:0] ptr
);

    logic [A_WIDTH-1:0] ptr_d;
    logic [A_WIDTH-1:0] ptr_q;

    // Clear wins over increment; the natural binary wrap covers DEPTH-1 -> 0.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + A_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller driving a simple dual-port RAM with 1-cycle read latency.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int D_WIDTH   = DEF_D_WIDTH,
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int AF_THRESH = def_af_thresh(A_WIDTH),
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [D_WIDTH-1:0] wr_data,
    output logic               full,
    output logic               almost_full,
    input  logic               rd_en,
    output logic               rd_valid,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               empty,
    output logic               almost_empty,
    output logic [A_WIDTH:0]   level,
    output logic               overflow,
    output logic               underflow,
    output logic               ram_write_enable,
    output logic [A_WIDTH-1:0] ram_address_write,
    output logic [D_WIDTH-1:0] ram_data_write,
    output logic [A_WIDTH-1:0] ram_address_read,
    input  logic [D_WIDTH-1:0] ram_data_read
);

    localparam int LW    = level_width(A_WIDTH);
    localparam int DEPTH = fifo_depth(A_WIDTH);

    logic [LW-1:0]      level_d, level_q;
    logic               rd_valid_d, rd_valid_q;
    logic               overflow_d, overflow_q;
    logic               underflow_d, underflow_q;
    logic               push_ok, pop_ok;
    logic [A_WIDTH-1:0] wr_ptr, rd_ptr;

    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LW'(AF_THRESH));
    assign almost_empty = (level_q <= LW'(AE_THRESH));

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when paired with a pop. Flush suppresses both.
    assign pop_ok  = rd_en & ~empty & ~flush;
    assign push_ok = wr_en & (~full | pop_ok) & ~flush;

    always_comb begin
        level_d     = level_q + LW'(push_ok) - LW'(pop_ok);
        rd_valid_d  = pop_ok;
        overflow_d  = overflow_q | (wr_en & full & ~pop_ok);
        underflow_d = underflow_q | (rd_en & empty);
        if (flush) begin
            level_d     = '0;
            rd_valid_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    ram_fifo_ptr #(.A_WIDTH(A_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push_ok),
        .ptr   (wr_ptr)
    );

    ram_fifo_ptr #(.A_WIDTH(A_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop_ok),
        .ptr   (rd_ptr)
    );

    // The RAM registers memory[rd_ptr] on the pop edge, so its output lines up
    // with rd_valid one cycle later without any extra staging here.
    assign ram_write_enable  = push_ok;
    assign ram_address_write = wr_ptr;
    assign ram_data_write    = wr_data;
    assign ram_address_read  = rd_ptr;

    assign rd_data   = ram_data_read;
    assign rd_valid  = rd_valid_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural registered-read dual-port RAM.
module tb_ram_fifo_ctrl;

    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, rd_valid, empty, almost_empty;
    logic [DW-1:0] rd_data;
    logic [AW:0]   level;
    logic          overflow, underflow;
    logic          ram_we;
    logic [AW-1:0] ram_aw, ram_ar;
    logic [DW-1:0] ram_dw, ram_dr;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Simple dual-port RAM, both ports on clk, read registered (old data on collision).
    always @(posedge clk) begin
        if (ram_we) mem[ram_aw] <= ram_dw;
        ram_dr <= mem[ram_ar];
    end

    ram_fifo_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .full              (full),
        .almost_full       (almost_full),
        .rd_en             (rd_en),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .empty             (empty),
        .almost_empty      (almost_empty),
        .level             (level),
        .overflow          (overflow),
        .underflow         (underflow),
        .ram_write_enable  (ram_we),
        .ram_address_write (ram_aw),
        .ram_data_write    (ram_dw),
        .ram_address_read  (ram_ar),
        .ram_data_read     (ram_dr)
    );

    typedef struct {
        logic          wr;
        logic          rd;
        logic          fl;
        logic [DW-1:0] d;
        int            lvl;
        logic          vld;
        logic [DW-1:0] rdata;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic wr, input logic rd, input logic fl,
                                input logic [DW-1:0] d, input int lvl, input logic vld,
                                input logic [DW-1:0] rdata, input logic ovf, input logic unf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.d = d; v.lvl = lvl;
        v.vld = vld; v.rdata = rdata; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_status(input string nm, input int lvl);
        chk({nm, " level"}, 32'(level), 32'(lvl));
        chk({nm, " empty"}, 32'(empty), 32'(lvl == 0));
        chk({nm, " full"}, 32'(full), 32'(lvl == 32));
        chk({nm, " almost_full"}, 32'(almost_full), 32'(lvl >= 30));
        chk({nm, " almost_empty"}, 32'(almost_empty), 32'(lvl <= 2));
    endtask

    // Drive one cycle of inputs and return 1 time unit after the edge.
    task automatic cyc(input logic wr, input logic rd, input logic fl, input logic [DW-1:0] d);
        wr_en = wr; rd_en = rd; flush = fl; wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ar_before;

        vecs[0] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);
        vecs[1] = mk(1, 1, 0, 16'h0011, 1, 0, 16'h0000, 0, 1);
        vecs[2] = mk(1, 0, 0, 16'h0022, 2, 0, 16'h0000, 0, 1);
        vecs[3] = mk(0, 1, 0, 16'h0000, 1, 1, 16'h0011, 0, 1);
        vecs[4] = mk(1, 1, 0, 16'h0033, 1, 1, 16'h0022, 0, 1);
        vecs[5] = mk(1, 1, 1, 16'h0099, 0, 0, 16'h0000, 0, 0);
        vecs[6] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        vecs[7] = mk(1, 0, 0, 16'h0044, 1, 0, 16'h0000, 0, 0);
        vecs[8] = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0044, 0, 0);
        vecs[9] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk_status("reset", 0);
        chk("reset rd_valid", 32'(rd_valid), 0);
        chk("reset overflow", 32'(overflow), 0);
        chk("reset underflow", 32'(underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].d);
            chk_status($sformatf("vec%0d", i), vecs[i].lvl);
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].vld));
            if (vecs[i].vld)
                chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rdata));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].unf));
        end

        // Fill from a clean state: 32 pushes of 0..31.
        cyc(0, 0, 1, '0);
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, 0, 16'(i));
            chk_status($sformatf("fill%0d", i), i + 1);
        end
        chk("fill overflow", 32'(overflow), 0);

        // Push while full is dropped; write enable must stay low.
        wr_en = 1'b1; wr_data = 16'hBEEF;
        #1;
        chk("full push we", 32'(ram_we), 0);
        cyc(1, 0, 0, 16'hBEEF);
        chk("full push overflow", 32'(overflow), 1);
        chk_status("full push", 32);

        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 0, '0);
            chk($sformatf("drain%0d rd_valid", i), 32'(rd_valid), 1);
            chk($sformatf("drain%0d rd_data", i), 32'(rd_data), 32'(i));
            chk($sformatf("drain%0d level", i), 32'(level), 32'(31 - i));
        end
        cyc(0, 0, 0, '0);
        chk("drain idle rd_valid", 32'(rd_valid), 0);
        chk_status("drained", 0);

        // Pop while empty.
        ar_before = ram_ar;
        cyc(0, 1, 0, '0);
        chk("empty pop underflow", 32'(underflow), 1);
        chk("empty pop rd_valid", 32'(rd_valid), 0);
        chk("empty pop rd_addr", 32'(ram_ar), 32'(ar_before));
        chk_status("empty pop", 0);

        // Refill, then stream push+pop at full for 40 cycles across the wrap.
        cyc(0, 0, 1, '0);
        for (int i = 0; i < 32; i++) cyc(1, 0, 0, 16'h0100 + 16'(i));
        chk_status("refill", 32);
        for (int k = 0; k < 40; k++) begin
            cyc(1, 1, 0, 16'hAAAA);
            chk($sformatf("stream%0d level", k), 32'(level), 32);
            chk($sformatf("stream%0d rd_valid", k), 32'(rd_valid), 1);
            chk($sformatf("stream%0d rd_data", k), 32'(rd_data),
                32'((k < 32) ? (16'h0100 + 16'(k)) : 16'hAAAA));
            chk($sformatf("stream%0d rd_addr", k), 32'(ram_ar), 32'((k + 1) % 32));
        end
        chk("stream overflow", 32'(overflow), 0);

        // Flush overrides simultaneous push and pop at level 5.
        cyc(0, 0, 1, '0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h0500 + 16'(i));
        cyc(0, 1, 0, '0);
        cyc(1, 0, 0, 16'h0505);
        chk_status("pre flush", 5);
        wr_en = 1'b1; rd_en = 1'b1; flush = 1'b1; wr_data = 16'h0777;
        #1;
        chk("flush we", 32'(ram_we), 0);
        cyc(1, 1, 1, 16'h0777);
        chk_status("flush", 0);
        chk("flush rd_valid", 32'(rd_valid), 0);
        chk("flush overflow", 32'(overflow), 0);
        chk("flush underflow", 32'(underflow), 0);
        cyc(1, 0, 0, 16'h1234);
        cyc(0, 1, 0, '0);
        chk("post flush rd_valid", 32'(rd_valid), 1);
        chk("post flush rd_data", 32'(rd_data), 32'h1234);

        // Asynchronous reset mid-burst at level 10 with rd_valid high.
        cyc(0, 0, 1, '0);
        cyc(0, 1, 0, '0);
        chk("pre reset underflow", 32'(underflow), 1);
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 16'h0A00 + 16'(i));
        cyc(0, 1, 0, '0);
        chk("pre reset rd_valid", 32'(rd_valid), 1);
        chk_status("pre reset", 10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset rd_valid", 32'(rd_valid), 0);
        chk("async reset underflow", 32'(underflow), 0);
        chk("async reset rd_addr", 32'(ram_ar), 0);
        chk_status("async reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 16'h5555);
        chk_status("resume push", 1);
        cyc(0, 1, 0, '0);
        chk("resume rd_valid", 32'(rd_valid), 1);
        chk("resume rd_data", 32'(rd_data), 32'h5555);
        chk_status("resume pop", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that wraps the team's simple dual-port RAM and turns it into a synchronous FIFO. Both RAM clocks are tied to clk. The block owns the RAM write port and read port (addresses, write enable) and produces full/empty/level status for the producer and consumer. It sits directly upstream of the RAM and drives every address and enable it sees.

Parameters:
D_WIDTH, 16, data word width; must match the RAM.
A_WIDTH, 5, RAM address width; FIFO depth DEPTH = 2**A_WIDTH.
AF_THRESH, 2**A_WIDTH-2, almost_full asserts when level >= AF_THRESH.
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH.

Ports:
clk  in  1  single clock; also drives the RAM clk_write and clk_read.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of pointers, level and error flags.
wr_en  in  1  push request.
wr_data  in  D_WIDTH  push data.
full  out  1  level == DEPTH.
almost_full  out  1  level >= AF_THRESH.
rd_en  in  1  pop request.
rd_valid  out  1  rd_data valid this cycle (popped the previous cycle).
rd_data  out  D_WIDTH  pop data; combinational pass-through of ram_data_read.
empty  out  1  level == 0.
almost_empty  out  1  level <= AE_THRESH.
level  out  A_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: push attempted while full and not simultaneously popped.
underflow  out  1  sticky: pop attempted while empty.
ram_write_enable  out  1  to RAM write_enable.
ram_address_write  out  A_WIDTH  to RAM address_write.
ram_data_write  out  D_WIDTH  to RAM data_write.
ram_address_read  out  A_WIDTH  to RAM address_read.
ram_data_read  in  D_WIDTH  from RAM data_read (registered in RAM, 1-cycle latency).

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, level=0, rd_valid=0, overflow=0, underflow=0. The outputs follow: empty=1, full=0, almost_empty=1, almost_full=0.
- Pointers are A_WIDTH wide, wrap naturally from DEPTH-1 to 0. Level is tracked separately in A_WIDTH+1 bits.
- push_ok = wr_en & (~full | pop_ok). pop_ok = rd_en & ~empty.
- RAM write port is combinational: ram_write_enable=push_ok, ram_address_write=wr_ptr, ram_data_write=wr_data. On a push, wr_ptr increments at the edge.
- RAM read port: ram_address_read=rd_ptr at all times. On a pop, rd_ptr increments at the edge. The RAM captures memory[rd_ptr] at that edge.
- rd_valid is registered pop_ok: high exactly one cycle after an accepted pop. rd_data equals ram_data_read. Read latency is 1 cycle.
- level next = level + push_ok - pop_ok.
- Simultaneous push and pop when empty: push accepted, pop rejected, underflow set, level becomes 1.
- Simultaneous push and pop when full: both accepted, level stays DEPTH. The write targets wr_ptr==rd_ptr. The RAM read on the same edge returns the old word, which is the correct output.
- Push while full without pop: dropped, no pointer or level change, overflow set.
- Pop while empty: no pointer change, rd_valid stays 0 next cycle, underflow set.
- flush: pointers, level, overflow and underflow are cleared at the edge, and rd_valid is 0 next cycle. flush overrides wr_en and rd_en in the same cycle; ram_write_enable is 0 while flush is high. RAM contents are not cleared.
- Status outputs are combinational from level.
- Sticky flags clear only on reset or flush.
- Reset asserted mid-operation: everything returns to reset values immediately. Any in-flight rd_valid is lost.

Decomposition:
- Shared package ram_fifo_pkg: DEPTH derivation, the level width constant A_WIDTH+1, and default threshold constants.
- One natural sub-module: ram_fifo_ptr (pointer register with enable, wrap, and synchronous clear), instantiated twice.
- The bench instantiates ram_fifo_ctrl together with the existing dual-port RAM, with both RAM clocks tied to clk.

Test Plan:
- Reset, then 32 pushes of 0x0000..0x001F with no pops -> full=1 after the 32nd push, level=32, almost_full first asserted at level=30, overflow=0.
- 33rd push of 0xBEEF while full -> overflow=1, level stays 32. A subsequent 32 pops return 0x0000..0x001F in order, each with rd_valid one cycle after rd_en. empty=1 at the end.
- Pop while empty -> underflow=1, rd_valid stays 0, ram_address_read unchanged.
- Full FIFO, simultaneous push of 0xAAAA and pop for 40 cycles -> level stays 32, output sequence continues in order, wrap of both pointers past 31 verified, 0xAAAA emerges after the original 32 words.
- Level 5 with push, pop and flush high in the same cycle -> next cycle level=0, empty=1, rd_valid=0, overflow=underflow=0. A following push/pop of 0x1234 returns 0x1234.
- Drop rst_n asynchronously mid-burst (level 10, rd_valid=1) -> rd_valid, level and flags go to 0 before the next edge. Operation resumes cleanly after rst_n rises.
